// File: rtl/asc_num_parser.sv
// ASCII number parser: pops characters from a show-ahead RX FIFO, accumulates
// decimal (or hex, when enabled) digits into a DATA_W-bit value and hands each
// completed number out on a valid/ready port. Illegal characters raise a
// one-cycle error pulse and the rest of that token is skipped.
module asc_num_parser #(
  parameter int DATA_W     = 16,
  parameter int MAX_DIGITS = 5,
  parameter int HEX_EN     = 0
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iFIFO_EMPTY,
  input  logic [7:0]        iASC,
  output logic              oFIFO_RD,
  input  logic              iRadix16,
  output logic [DATA_W-1:0] oValue,
  output logic [3:0]        oDigits,
  output logic              oOvf,
  output logic              oValid,
  input  logic              iReady,
  output logic              oErr
);

  // Four spare bits keep acc*16+15 exact for any in-range acc.
  localparam int              ACC_W   = DATA_W + 4;
  localparam logic [ACC_W-1:0] ACC_SAT = {4'b0000, {DATA_W{1'b1}}};
  localparam logic [3:0]      MAX_D   = 4'(MAX_DIGITS);
  localparam logic            HEX_ON  = (HEX_EN != 0);

  typedef enum logic [1:0] {IDLE, ACCUM, SKIP, EMIT} state_t;

  state_t             state, state_n;
  logic [ACC_W-1:0]   acc, acc_n;
  logic [3:0]         digits, digits_n;
  logic               ovf, ovf_n;
  logic               radix16, radix16_n;
  logic [DATA_W-1:0]  out_value, out_value_n;
  logic [3:0]         out_digits, out_digits_n;
  logic               out_ovf, out_ovf_n;
  logic               out_valid, out_valid_n;
  logic               err_pulse, err_pulse_n;

  logic               pop;
  logic               hex_sel;
  logic [4:0]         dv;
  logic               delim;
  logic [ACC_W-1:0]   acc_step;
  logic [3:0]         dig_inc;

  function automatic logic is_delim(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h2C) || (c == 8'h0D) || (c == 8'h0A);
  endfunction

  // Returns {is_digit, value}; hex letters only count when hex is set.
  function automatic logic [4:0] digit_of(input logic [7:0] c, input logic hex);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)
      r = {1'b1, c[3:0]};
    else if (hex && ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)))
      r = {1'b1, c[3:0] + 4'd9};
    return r;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] n);
    return (n == 4'hF) ? n : n + 4'd1;
  endfunction

  function automatic logic [ACC_W-1:0] scale_add(input logic [ACC_W-1:0] a,
                                                  input logic hex,
                                                  input logic [3:0] d);
    logic [ACC_W-1:0] m;
    m = hex ? (a << 4) : ((a << 3) + (a << 1));
    return m + {{(ACC_W-4){1'b0}}, d};
  endfunction

  // The radix in force is the live input only while waiting for a first digit.
  assign hex_sel  = (state == IDLE) ? (HEX_ON && iRadix16) : radix16;
  assign dv       = digit_of(iASC, hex_sel);
  assign delim    = is_delim(iASC);
  assign acc_step = scale_add(acc, radix16, dv[3:0]);
  assign dig_inc  = sat_inc4(digits);
  assign pop      = !iFIFO_EMPTY && (state != EMIT);

  assign oFIFO_RD = pop;
  assign oValue   = out_value;
  assign oDigits  = out_digits;
  assign oOvf     = out_ovf;
  assign oValid   = out_valid;
  assign oErr     = err_pulse;

  // Next-state and next-output logic for the parser FSM.
  always_comb begin
    state_n      = state;
    acc_n        = acc;
    digits_n     = digits;
    ovf_n        = ovf;
    radix16_n    = radix16;
    out_value_n  = out_value;
    out_digits_n = out_digits;
    out_ovf_n    = out_ovf;
    out_valid_n  = out_valid;
    err_pulse_n  = 1'b0;
    case (state)
      IDLE: begin
        if (pop) begin
          if (dv[4]) begin
            acc_n     = {{(ACC_W-4){1'b0}}, dv[3:0]};
            digits_n  = 4'd1;
            ovf_n     = 1'b0;
            radix16_n = hex_sel;
            state_n   = ACCUM;
          end else if (!delim) begin
            err_pulse_n = 1'b1;
            state_n     = SKIP;
          end
        end
      end
      ACCUM: begin
        if (pop) begin
          if (dv[4]) begin
            digits_n = dig_inc;
            if (!ovf) begin
              if (acc_step > ACC_SAT || dig_inc > MAX_D) begin
                acc_n = ACC_SAT;
                ovf_n = 1'b1;
              end else begin
                acc_n = acc_step;
              end
            end
          end else if (delim) begin
            out_value_n  = acc[DATA_W-1:0];
            out_digits_n = digits;
            out_ovf_n    = ovf;
            out_valid_n  = 1'b1;
            state_n      = EMIT;
          end else begin
            err_pulse_n = 1'b1;
            acc_n       = '0;
            digits_n    = 4'd0;
            ovf_n       = 1'b0;
            state_n     = SKIP;
          end
        end
      end
      SKIP: begin
        if (pop && delim) state_n = IDLE;
      end
      EMIT: begin
        if (iReady) begin
          out_valid_n = 1'b0;
          acc_n       = '0;
          digits_n    = 4'd0;
          ovf_n       = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state      <= IDLE;
      acc        <= '0;
      digits     <= 4'd0;
      ovf        <= 1'b0;
      radix16    <= 1'b0;
      out_value  <= '0;
      out_digits <= 4'd0;
      out_ovf    <= 1'b0;
      out_valid  <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      digits     <= digits_n;
      ovf        <= ovf_n;
      radix16    <= radix16_n;
      out_value  <= out_value_n;
      out_digits <= out_digits_n;
      out_ovf    <= out_ovf_n;
      out_valid  <= out_valid_n;
      err_pulse  <= err_pulse_n;
    end
  end

endmodule

// File: tb/tb_asc_num_parser.sv
// Bench for asc_num_parser: a FIFO model feeds characters, a token-level
// reference model predicts oFIFO_RD/oValid/oErr and the emitted fields, and
// directed sequences check the decoded numbers against fixed values.
module tb_asc_num_parser;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        iFIFO_EMPTY = 1'b1;
  logic [7:0]  iASC = 8'h00;
  logic        oFIFO_RD;
  logic        iRadix16 = 1'b0;
  logic [15:0] oValue;
  logic [3:0]  oDigits;
  logic        oOvf;
  logic        oValid;
  logic        iReady = 1'b0;
  logic        oErr;

  asc_num_parser #(.DATA_W(16), .MAX_DIGITS(5), .HEX_EN(1)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iFIFO_EMPTY(iFIFO_EMPTY), .iASC(iASC),
    .oFIFO_RD(oFIFO_RD), .iRadix16(iRadix16), .oValue(oValue),
    .oDigits(oDigits), .oOvf(oOvf), .oValid(oValid), .iReady(iReady),
    .oErr(oErr)
  );

  always #5 iClk = ~iClk;

  int checks = 0;
  int errors = 0;

  // FIFO contents and the radix input to present alongside each character.
  byte unsigned fifo[$];
  bit           rfifo[$];

  // Reference model state.
  int unsigned  tok[$];
  bit           tok_hex;
  bit           in_skip;
  bit           exp_valid;
  bit           exp_err;
  int unsigned  exp_val;
  int unsigned  exp_dig;
  bit           exp_ovf;

  // Observed transfers {ovf, digits, value} and error pulses.
  logic [20:0]  got[$];
  int           err_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit is_delim(input byte unsigned c);
    return c == 8'h20 || c == 8'h2C || c == 8'h0D || c == 8'h0A;
  endfunction

  function automatic int dval(input byte unsigned c, input bit hex);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (hex && c >= "A" && c <= "F") return int'(c) - 55;
    if (hex && c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  task automatic push_str(input string s, input bit hex);
    for (int i = 0; i < s.len(); i++) begin
      fifo.push_back(s[i]);
      rfifo.push_back(hex);
    end
  endtask

  // Evaluate a whole token arithmetically once its delimiter arrives.
  task automatic finish_token();
    longint v;
    bit     o;
    v = 0;
    o = (tok.size() > 5);
    foreach (tok[i]) begin
      v = v * (tok_hex ? 16 : 10) + tok[i];
      if (v > 65535) begin
        o = 1'b1;
        v = 65535;
      end
    end
    exp_val   = o ? 65535 : int'(v);
    exp_dig   = (tok.size() > 15) ? 15 : tok.size();
    exp_ovf   = o;
    exp_valid = 1'b1;
    tok.delete();
  endtask

  task automatic model_edge(input bit rst_n_v, input bit popped, input byte unsigned c,
                            input bit hex, input bit rdy);
    bit new_err;
    int d;
    if (!rst_n_v) begin
      tok.delete();
      in_skip   = 1'b0;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      return;
    end
    new_err = 1'b0;
    if (exp_valid && rdy) exp_valid = 1'b0;
    if (popped) begin
      if (in_skip) begin
        if (is_delim(c)) in_skip = 1'b0;
      end else if (is_delim(c)) begin
        if (tok.size() > 0) finish_token();
      end else begin
        if (tok.size() == 0) tok_hex = hex;
        d = dval(c, tok_hex);
        if (d >= 0) tok.push_back(d);
        else begin
          new_err = 1'b1;
          in_skip = 1'b1;
          tok.delete();
        end
      end
    end
    exp_err = new_err;
  endtask

  // One clock: drive inputs, check the pop strobe, advance, check outputs.
  task automatic step(input bit rst_n_v, input bit stall, input bit rdy);
    bit           rd;
    bit           empty;
    byte unsigned c;
    bit           hx;
    empty = stall || (fifo.size() == 0);
    c     = (fifo.size() != 0) ? fifo[0] : 8'h00;
    hx    = (fifo.size() != 0) ? rfifo[0] : 1'b0;
    iRst_n      = rst_n_v;
    iFIFO_EMPTY = empty;
    iASC        = c;
    iRadix16    = hx;
    iReady      = rdy;
    #1;
    chk("fifo_rd", {31'd0, oFIFO_RD}, {31'd0, (!empty && !exp_valid)});
    rd = oFIFO_RD;
    if (rst_n_v && oValid === 1'b1 && rdy) got.push_back({oOvf, oDigits, oValue});
    @(posedge iClk);
    if (rd && !empty) begin
      void'(fifo.pop_front());
      void'(rfifo.pop_front());
    end
    model_edge(rst_n_v, rd && !empty, c, hx, rdy);
    #1;
    if (oErr === 1'b1) err_cnt++;
    chk("valid", {31'd0, oValid}, {31'd0, exp_valid});
    chk("err", {31'd0, oErr}, {31'd0, exp_err});
    if (exp_valid) begin
      chk("value", {16'd0, oValue}, exp_val);
      chk("digits", {28'd0, oDigits}, exp_dig);
      chk("ovf", {31'd0, oOvf}, {31'd0, exp_ovf});
    end
  endtask

  // Run until the FIFO is drained and no number is pending; hold iReady low
  // for 'hold' cycles after the first oValid.
  task automatic drain(input int budget, input int hold);
    int n;
    int seen;
    bit rdy;
    n = 0;
    seen = 0;
    while (!(fifo.size() == 0 && !exp_valid)) begin
      if (n >= budget) begin
        chk("drain_timeout", n, budget + 1);
        break;
      end
      rdy = (hold == 0) || (seen > hold);
      step(1'b1, 1'b0, rdy);
      if (exp_valid) seen++;
      n++;
    end
  endtask

  task automatic start_seq();
    got.delete();
    err_cnt = 0;
  endtask

  task automatic chk_num(input string tag, input int idx, input int v, input int dg, input bit o);
    logic [20:0] g;
    g = (idx < got.size()) ? got[idx] : 21'h1FFFFF;
    chk({tag, "_val"}, {16'd0, g[15:0]}, v);
    chk({tag, "_dig"}, {28'd0, g[19:16]}, dg);
    chk({tag, "_ovf"}, {31'd0, g[20]}, {31'd0, o});
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_value"}, {16'd0, oValue}, 0);
    chk({tag, "_digits"}, {28'd0, oDigits}, 0);
    chk({tag, "_ovf"}, {31'd0, oOvf}, 0);
    chk({tag, "_valid"}, {31'd0, oValid}, 0);
    chk({tag, "_err"}, {31'd0, oErr}, 0);
  endtask

  string alpha = "0123456789abcdefABCDEFxG!: 0123456789 ,\r\n7";

  initial begin
    in_skip = 0; exp_valid = 0; exp_err = 0; tok_hex = 0; err_cnt = 0;

    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk_zero_outputs("reset");

    start_seq();
    push_str("123 ", 1'b0);
    drain(100, 0);
    chk("n123_cnt", got.size(), 1);
    chk_num("n123", 0, 123, 3, 1'b0);

    start_seq();
    push_str("65535,65536\r000007 ", 1'b0);
    drain(200, 0);
    chk("ovf_cnt", got.size(), 3);
    chk_num("max", 0, 65535, 5, 1'b0);
    chk_num("over", 1, 65535, 5, 1'b1);
    chk_num("sixdig", 2, 65535, 6, 1'b1);

    start_seq();
    push_str("12a4 5 ", 1'b0);
    drain(100, 0);
    chk("illegal_errs", err_cnt, 1);
    chk("illegal_cnt", got.size(), 1);
    chk_num("after_err", 0, 5, 1, 1'b0);

    start_seq();
    push_str("42 9 ", 1'b0);
    drain(100, 6);
    chk("bp_cnt", got.size(), 2);
    chk_num("bp42", 0, 42, 2, 1'b0);
    chk_num("bp9", 1, 9, 1, 1'b0);

    start_seq();
    push_str("Ff ", 1'b1);
    push_str("Ff ", 1'b0);
    drain(100, 0);
    chk("hex_cnt", got.size(), 1);
    chk("hex_errs", err_cnt, 1);
    chk_num("hexff", 0, 255, 2, 1'b0);

    start_seq();
    push_str("1", 1'b1);
    push_str("f ", 1'b0);
    push_str("FFFFF ", 1'b1);
    drain(100, 0);
    chk("latch_cnt", got.size(), 2);
    chk_num("latch", 0, 31, 2, 1'b0);
    chk_num("hexovf", 1, 65535, 5, 1'b1);

    start_seq();
    push_str("12", 1'b0);
    drain(50, 0);
    step(1'b0, 1'b1, 1'b1);
    chk_zero_outputs("midrst");
    push_str("3  , 7 ", 1'b0);
    drain(100, 0);
    chk("midrst_cnt", got.size(), 2);
    chk_num("midrst3", 0, 3, 1, 1'b0);
    chk_num("midrst7", 1, 7, 1, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      while (fifo.size() < 4) begin
        fifo.push_back(alpha[$urandom_range(alpha.len() - 1)]);
        rfifo.push_back(1'($urandom_range(1)));
      end
      step(($urandom_range(599) != 0), ($urandom_range(4) == 0), ($urandom_range(3) != 0));
    end
    drain(200, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
